// File: rtl/pwm_modulator_pkg.sv
// Shared definitions for the PWM modulator and the waveform generators feeding it.
package pwm_modulator_pkg;

    localparam int DUTY_W_DEF = 6;
    localparam int PRE_W_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } pwm_state_t;

    // True whenever the modulator is producing (or finishing) a period.
    function automatic logic is_active(input pwm_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Divides the system clock down to PWM ticks: one tick every limit+1 cycles while running.
module pwm_tick_prescaler #(
    parameter int PRE_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [PRE_W-1:0] limit,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;
    logic             at_limit;

    // Next-count logic; >= keeps the counter safe if the limit ever drops below it.
    always_comb begin
        at_limit = (cnt_q >= limit);
        tick     = run && !load && at_limit;
        cnt_d    = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (run) begin
            if (at_limit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_modulator.sv
// PWM modulator: latches one duty sample per period, requests the next one, stops at a period edge.
module pwm_modulator
    import pwm_modulator_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int PRE_W  = PRE_W_DEF
) (
    input  logic              sysclk,
    input  logic              Reset_N,
    input  logic              Enable_SW_1,
    input  logic [DUTY_W-1:0] Duty_Input,
    input  logic [PRE_W-1:0]  Prescale,
    output logic              PWM_Out,
    output logic              Sample_Req,
    output logic              Busy
);

    pwm_state_t        state_q;
    pwm_state_t        state_d;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic [DUTY_W-1:0] period_q;
    logic [DUTY_W-1:0] period_d;
    logic              pwm_q;
    logic              pwm_d;
    logic              req_q;
    logic              req_d;
    logic              busy_q;
    logic              busy_d;

    logic              tick;
    logic              start;
    logic              period_start;
    logic              final_edge;

    assign start = (state_q == IDLE) && Enable_SW_1;

    pwm_tick_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk   (sysclk),
        .rst_n (Reset_N),
        .run   (is_active(state_q)),
        .load  (start),
        .limit (pre_q),
        .tick  (tick)
    );

    // FSM next-state, duty/prescale latching, period counting and output decode.
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        pre_d        = pre_q;
        period_d     = period_q;
        req_d        = 1'b0;
        period_start = tick && (period_q == '1);
        final_edge   = (state_q == STOPPING) && period_start;

        if (tick) begin
            period_d = period_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (Enable_SW_1) begin
                    state_d  = RUN;
                    duty_d   = Duty_Input;
                    pre_d    = Prescale;
                    period_d = '0;
                    req_d    = 1'b1;
                end
            end
            RUN: begin
                if (period_start) begin
                    duty_d = Duty_Input;
                    pre_d  = Prescale;
                    req_d  = 1'b1;
                end
                if (!Enable_SW_1) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (period_start) begin
                    state_d = IDLE;
                end else if (Enable_SW_1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pwm_d  = is_active(state_q) && !final_edge && (period_q < duty_q);
        busy_d = is_active(state_d);
    end

    // State and registered outputs; reset clears every output immediately.
    always_ff @(posedge sysclk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            pre_q    <= '0;
            period_q <= '0;
            pwm_q    <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            pre_q    <= pre_d;
            period_q <= period_d;
            pwm_q    <= pwm_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
        end
    end

    assign PWM_Out    = pwm_q;
    assign Sample_Req = req_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed testbench for pwm_modulator: table of full periods plus hand-written corner sequences.
module tb_pwm_modulator;

    logic       sysclk;
    logic       Reset_N;
    logic       Enable_SW_1;
    logic [5:0] Duty_Input;
    logic [5:0] Prescale;
    logic       PWM_Out;
    logic       Sample_Req;
    logic       Busy;

    int checks;
    int errors;

    int win_j;
    int win_high;
    int win_req;
    int win_pat;
    int win_busy_low;

    typedef struct {
        int    next_duty;
        int    next_pre;
        int    cur_duty;
        int    cur_pre;
        int    exp_high;
        string name;
    } vec_t;

    vec_t vecs[5];

    pwm_modulator dut (
        .sysclk      (sysclk),
        .Reset_N     (Reset_N),
        .Enable_SW_1 (Enable_SW_1),
        .Duty_Input  (Duty_Input),
        .Prescale    (Prescale),
        .PWM_Out     (PWM_Out),
        .Sample_Req  (Sample_Req),
        .Busy        (Busy)
    );

    // 100 MHz system clock.
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Drive the three functional inputs together.
    task automatic applyStimulus(input logic en, input int duty, input int pre);
        Enable_SW_1 = en;
        Duty_Input  = 6'(duty);
        Prescale    = 6'(pre);
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic start_window();
        win_j        = 0;
        win_high     = 0;
        win_req      = 0;
        win_pat      = 0;
        win_busy_low = 0;
    endtask

    // Run n cycles, accumulating statistics; after edge j of a period PWM shows count (j-1)/(P+1).
    task automatic run_cycles(input int n, input int cur_duty, input int cur_pre);
        logic exp_bit;
        for (int i = 0; i < n; i++) begin
            step();
            win_j++;
            if (PWM_Out)    win_high++;
            if (Sample_Req) win_req++;
            if (!Busy)      win_busy_low++;
            exp_bit = (((win_j - 1) / (cur_pre + 1)) < cur_duty);
            if (PWM_Out !== exp_bit) win_pat++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{next_duty: 16, next_pre: 0, cur_duty: 16, cur_pre: 0, exp_high: 16,  name: "d16_p0_a"};
        vecs[1] = '{next_duty: 0,  next_pre: 3, cur_duty: 16, cur_pre: 0, exp_high: 16,  name: "d16_p0_b"};
        vecs[2] = '{next_duty: 63, next_pre: 3, cur_duty: 0,  cur_pre: 3, exp_high: 0,   name: "d0_p3"};
        vecs[3] = '{next_duty: 10, next_pre: 0, cur_duty: 63, cur_pre: 3, exp_high: 252, name: "d63_p3"};
        vecs[4] = '{next_duty: 10, next_pre: 0, cur_duty: 10, cur_pre: 0, exp_high: 10,  name: "d10_p0"};

        Reset_N = 1'b0;
        applyStimulus(1'b0, 0, 0);
        #12;
        checkOutput("reset_pwm", int'(PWM_Out), 0);
        checkOutput("reset_req", int'(Sample_Req), 0);
        checkOutput("reset_busy", int'(Busy), 0);

        @(posedge sysclk);
        #1;
        Reset_N = 1'b1;
        start_window();
        run_cycles(5, 0, 0);
        checkOutput("idle_busy_low", win_busy_low, 5);
        checkOutput("idle_req", win_req, 0);
        checkOutput("idle_high", win_high, 0);

        applyStimulus(1'b1, 16, 0);
        step();
        checkOutput("start_req", int'(Sample_Req), 1);
        checkOutput("start_busy", int'(Busy), 1);
        checkOutput("start_pwm", int'(PWM_Out), 0);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(1'b1, vecs[v].next_duty, vecs[v].next_pre);
            start_window();
            run_cycles(64 * (vecs[v].cur_pre + 1), vecs[v].cur_duty, vecs[v].cur_pre);
            checkOutput({vecs[v].name, "_high"}, win_high, vecs[v].exp_high);
            checkOutput({vecs[v].name, "_req"}, win_req, 1);
            checkOutput({vecs[v].name, "_pattern"}, win_pat, 0);
            checkOutput({vecs[v].name, "_busy"}, win_busy_low, 0);
            checkOutput({vecs[v].name, "_req_at_wrap"}, int'(Sample_Req), 1);
        end

        // Duty changes mid-period are held off until the next boundary.
        start_window();
        run_cycles(20, 10, 0);
        applyStimulus(1'b1, 40, 0);
        run_cycles(44, 10, 0);
        checkOutput("midchg_high", win_high, 10);
        checkOutput("midchg_pattern", win_pat, 0);
        checkOutput("midchg_req", win_req, 1);
        applyStimulus(1'b1, 32, 0);
        start_window();
        run_cycles(64, 40, 0);
        checkOutput("midchg_next_high", win_high, 40);
        checkOutput("midchg_next_pattern", win_pat, 0);

        // Disable partway through a duty-32 period: finish it, then go quiet.
        start_window();
        run_cycles(21, 32, 0);
        applyStimulus(1'b0, 32, 0);
        run_cycles(42, 32, 0);
        checkOutput("stop_busy_before_wrap", int'(Busy), 1);
        run_cycles(1, 32, 0);
        checkOutput("stop_busy_at_wrap", int'(Busy), 0);
        checkOutput("stop_high", win_high, 32);
        checkOutput("stop_pattern", win_pat, 0);
        checkOutput("stop_req", win_req, 0);
        start_window();
        run_cycles(10, 0, 0);
        checkOutput("after_stop_high", win_high, 0);
        checkOutput("after_stop_req", win_req, 0);
        checkOutput("after_stop_busy_low", win_busy_low, 10);

        // Re-raising enable before the wrap keeps periods continuous.
        applyStimulus(1'b1, 32, 0);
        step();
        checkOutput("restart_req", int'(Sample_Req), 1);
        start_window();
        run_cycles(21, 32, 0);
        applyStimulus(1'b0, 32, 0);
        run_cycles(9, 32, 0);
        applyStimulus(1'b1, 32, 0);
        run_cycles(34, 32, 0);
        checkOutput("reenable_high", win_high, 32);
        checkOutput("reenable_req", win_req, 1);
        checkOutput("reenable_busy_low", win_busy_low, 0);

        // Enable falls exactly on a RUN boundary: latch, request, then one more full period.
        start_window();
        run_cycles(63, 32, 0);
        applyStimulus(1'b0, 32, 0);
        run_cycles(1, 32, 0);
        checkOutput("edge_stop_req_at_wrap", int'(Sample_Req), 1);
        checkOutput("edge_stop_busy_at_wrap", int'(Busy), 1);
        checkOutput("edge_stop_high", win_high, 32);
        start_window();
        run_cycles(64, 32, 0);
        checkOutput("extra_period_high", win_high, 32);
        checkOutput("extra_period_pattern", win_pat, 0);
        checkOutput("extra_period_req", win_req, 0);
        checkOutput("extra_period_busy_low", win_busy_low, 1);

        // Asynchronous reset in the middle of a high pulse.
        applyStimulus(1'b1, 20, 1);
        step();
        start_window();
        run_cycles(5, 20, 1);
        checkOutput("pre_reset_pwm", int'(PWM_Out), 1);
        #2;
        Reset_N = 1'b0;
        #1;
        checkOutput("async_reset_pwm", int'(PWM_Out), 0);
        checkOutput("async_reset_busy", int'(Busy), 0);
        checkOutput("async_reset_req", int'(Sample_Req), 0);
        applyStimulus(1'b0, 20, 1);
        @(posedge sysclk);
        #1;
        Reset_N = 1'b1;
        start_window();
        run_cycles(4, 0, 0);
        checkOutput("post_reset_busy_low", win_busy_low, 4);
        checkOutput("post_reset_high", win_high, 0);
        applyStimulus(1'b1, 20, 1);
        step();
        checkOutput("post_reset_start_req", int'(Sample_Req), 1);
        checkOutput("post_reset_start_busy", int'(Busy), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
